// File: rtl/mod_sequencer.sv
// Modulation sample sequencer: walks a sample buffer at a programmable rate, fetches each
// sample from a 2-cycle-latency BRAM and issues it to the modulator with an UPDATE pulse,
// never while a computation is still in flight.
// Build option: define MOD_SEQ_SKIP_EN to advance the index on ticks that arrive while busy
// (keeping phase across devices) instead of deferring one tick as pending.
module mod_sequencer #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  sync_i,
    input  logic [ADDR_WIDTH-1:0] mod_cycle_i,
    input  logic [DIV_WIDTH-1:0]  mod_freq_div_i,
    output logic [ADDR_WIDTH-1:0] mod_addr_o,
    input  logic [7:0]            mod_rdata_i,
    output logic                  update_o,
    output logic [7:0]            mod_o,
    input  logic                  out_valid_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic                  overrun_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWaitDone, StDrain} state_e;

    state_e                state_q, state_d;
    logic                  fetch_cnt_q, fetch_cnt_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  ov_prev_q;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] mod_addr_q, mod_addr_d;
    logic                  update_q, update_d;
    logic                  busy_q, busy_d;
    logic [7:0]            mod_q, mod_d;

    logic tick;
    logic ov_rise;
    logic start;
    logic issue;
    logic in_flight;

    // Wrap with >= so an index left beyond a shortened cycle returns to 0.
    function automatic logic [ADDR_WIDTH-1:0] next_idx(input logic [ADDR_WIDTH-1:0] cur,
                                                       input logic [ADDR_WIDTH-1:0] last);
        return (cur >= last) ? '0 : cur + ADDR_WIDTH'(1);
    endfunction

    // Only a low-to-high OUT_VALID transition marks completion; the stale level is ignored.
    assign ov_rise   = out_valid_i & ~ov_prev_q;
    assign tick      = sync_i | (enable_i & (div_cnt_q >= mod_freq_div_i));
    assign start     = (state_q == StIdle) & enable_i & (tick | pending_q);
    assign issue     = (state_q == StIssue) & enable_i;
    assign in_flight = (state_q == StFetch) | (state_q == StIssue) | (state_q == StWaitDone);

    // Sample-period divider; SYNC realigns it, disable parks it at 0.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        if (sync_i || !enable_i || (div_cnt_q >= mod_freq_div_i)) begin
            div_cnt_d = '0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            fetch_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Next-state logic; FETCH lasts two cycles to cover the BRAM read latency.
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                fetch_cnt_d = ~fetch_cnt_q;
                if (!enable_i)        state_d = StIdle;
                else if (fetch_cnt_q) state_d = StIssue;
            end
            StIssue: begin
                state_d = enable_i ? StWaitDone : StIdle;
            end
            StWaitDone: begin
                if (ov_rise)        state_d = StIdle;
                else if (!enable_i) state_d = StDrain;
            end
            StDrain: begin
                if (ov_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        mod_addr_d = mod_addr_q;
        mod_d      = mod_q;
        update_d   = 1'b0;
        busy_d     = busy_q;
        if (start) begin
            // A SYNC in the same cycle already restarts the sequence at 0.
            mod_addr_d = sync_i ? '0 : idx_q;
        end
        if (issue) begin
            mod_d    = mod_rdata_i;
            update_d = 1'b1;
            busy_d   = 1'b1;
        end
        if (((state_q == StWaitDone) || (state_q == StDrain)) && ov_rise) begin
            busy_d = 1'b0;
        end
    end

    // Index, pending-tick and overrun bookkeeping.
    always_comb begin
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (issue) begin
            idx_d = next_idx(idx_d, mod_cycle_i);
        end
        if (!enable_i) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else if (start) begin
            pending_d = 1'b0;
        end else if (tick && in_flight) begin
`ifdef MOD_SEQ_SKIP_EN
            idx_d     = next_idx(idx_d, mod_cycle_i);
            overrun_d = 1'b1;
`else
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
`endif
        end
        if (sync_i) begin
            idx_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ov_prev_q  <= 1'b0;
            idx_q      <= '0;
            mod_addr_q <= '0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            mod_q      <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ov_prev_q  <= out_valid_i;
            idx_q      <= idx_d;
            mod_addr_q <= mod_addr_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            mod_q      <= mod_d;
        end
    end

    assign mod_addr_o = mod_addr_q;
    assign update_o   = update_q;
    assign mod_o      = mod_q;
    assign busy_o     = busy_q;
    assign idx_o      = idx_q;
    assign overrun_o  = overrun_q;

endmodule
